// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one spi_full_duplex master port.
// Optional macro SPI_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES cycles.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 18,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                      sys_clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_mode,
    input  logic [NUM_REQ*2-1:0]      req_speed,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      spi_tx_enable,
    output logic [DATA_W-1:0]         spi_data_in,
    output logic [1:0]                spi_mode,
    output logic [1:0]                spi_clock_speed,
    input  logic                      spi_rx_valid,
    input  logic [DATA_W-1:0]         spi_rx_data,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                busy_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     last_grant_q;
    logic                tx_en_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          mode_q;
    logic [1:0]          speed_q;
    logic [3:0]          gap_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]    tmo_q;
    logic                rsp_timeout_q;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ack_q        <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            tx_en_q      <= 1'b0;
            data_q       <= '0;
            mode_q       <= '0;
            speed_q      <= '0;
            gap_q        <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q <= win_id;
                        data_q  <= req_data[DATA_W*int'(win_id) +: DATA_W];
                        mode_q  <= req_mode[2*int'(win_id) +: 2];
                        speed_q <= req_speed[2*int'(win_id) +: 2];
                        tx_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tx_en_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_rx_valid) begin
                        rsp_data_q     <= spi_rx_data;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= S_RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_q     <= '0;
                        rsp_timeout_q  <= 1'b1;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    ack_q        <= '0;
                    last_grant_q <= grant_q;
                    gap_q        <= 4'(GAP_CYCLES);
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_timeout_q <= 1'b0;
`endif
                    state_q      <= S_GAP;
                end
                S_GAP: begin
                    // Leaves as the counter reaches zero: exactly GAP_CYCLES cycles spent here.
                    gap_q <= gap_q - 4'd1;
                    if (gap_q <= 4'd1) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ack_q   <= '0;
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack             = ack_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;
    assign spi_tx_enable   = tx_en_q;
    assign spi_data_in     = data_q;
    assign spi_mode        = mode_q;
    assign spi_clock_speed = speed_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: single request, fairness, wrap-around, spurious rx, reset, timeout.
module tb_spi_txn_arbiter;

    logic         sys_clock;
    logic         reset_n;
    logic [3:0]   req;
    logic [71:0]  req_data;
    logic [7:0]   req_mode;
    logic [7:0]   req_speed;
    logic [3:0]   ack;
    logic [17:0]  rsp_data;
    logic         rsp_timeout;
    logic         busy;
    logic [1:0]   grant_id;
    logic         spi_tx_enable;
    logic [17:0]  spi_data_in;
    logic [1:0]   spi_mode;
    logic [1:0]   spi_clock_speed;
    logic         spi_rx_valid;
    logic [17:0]  spi_rx_data;
    logic [2:0]   dbg_state;

    int checks;
    int failures;

    logic [17:0] dtab [4];
    logic [1:0]  mtab [4];
    logic [1:0]  stab [4];

    spi_txn_arbiter #(
        .NUM_REQ(4), .DATA_W(18), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .req(req),
        .req_data(req_data), .req_mode(req_mode), .req_speed(req_speed),
        .ack(ack), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
        .grant_id(grant_id), .spi_tx_enable(spi_tx_enable), .spi_data_in(spi_data_in),
        .spi_mode(spi_mode), .spi_clock_speed(spi_clock_speed),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .dbg_state(dbg_state)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [3:0] r, input int g, input logic [17:0] rx, output int lat);
        int n;
        n = 0;
        req = r;
        do begin
            step();
            n++;
        end while (!spi_tx_enable && n < 20);
        lat = n;
        check("tx_enable_seen", 32'(spi_tx_enable), 32'd1);
        check("grant_id", 32'(grant_id), 32'(g));
        check("spi_data_in", 32'(spi_data_in), 32'(dtab[g]));
        check("spi_mode", 32'(spi_mode), 32'(mtab[g]));
        check("spi_clock_speed", 32'(spi_clock_speed), 32'(stab[g]));
        step();
        check("tx_one_cycle", 32'(spi_tx_enable), 32'd0);
        spi_rx_valid = 1'b1;
        spi_rx_data  = rx;
        step();
        spi_rx_valid = 1'b0;
        spi_rx_data  = '0;
        check("ack", 32'(ack), 32'd1 << g);
        check("rsp_data", 32'(rsp_data), 32'(rx));
        check("rsp_timeout_clear", 32'(rsp_timeout), 32'd0);
    endtask

    initial begin
        int lat;
        int early;
        checks       = 0;
        failures     = 0;
        dtab[0] = 18'h2A5A5; dtab[1] = 18'h0C3C3; dtab[2] = 18'h31111; dtab[3] = 18'h3FFFF;
        mtab[0] = 2'b01;     mtab[1] = 2'b10;     mtab[2] = 2'b11;     mtab[3] = 2'b00;
        stab[0] = 2'b10;     stab[1] = 2'b01;     stab[2] = 2'b00;     stab[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_data[18*i +: 18] = dtab[i];
            req_mode[2*i +: 2]   = mtab[i];
            req_speed[2*i +: 2]  = stab[i];
        end
        reset_n      = 1'b0;
        req          = '0;
        spi_rx_valid = 1'b0;
        spi_rx_data  = '0;

        repeat (3) step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_tx", 32'(spi_tx_enable), 32'd0);
        check("rst_data_in", 32'(spi_data_in), 32'd0);
        check("rst_mode", 32'(spi_mode), 32'd0);
        check("rst_speed", 32'(spi_clock_speed), 32'd0);
        reset_n = 1'b1;
        step();

        // Single request, then spurious rx_valid in GAP and IDLE.
        txn(4'b0001, 0, 18'h15A5A, lat);
        check("first_latency", 32'(lat), 32'd1);
        req = '0;
        step();
        check("gap1_ack", 32'(ack), 32'd0);
        check("gap1_busy", 32'(busy), 32'd1);
        check("gap1_data_stable", 32'(spi_data_in), 32'h2A5A5);
        spi_rx_valid = 1'b1;
        spi_rx_data  = 18'h3FFFF;
        step();
        spi_rx_valid = 1'b0;
        check("gap_spurious_ack", 32'(ack), 32'd0);
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("gap_spurious_rsp", 32'(rsp_data), 32'h15A5A);
        spi_rx_valid = 1'b1;
        spi_rx_data  = 18'h12345;
        step();
        spi_rx_valid = 1'b0;
        check("idle_spurious_ack", 32'(ack), 32'd0);
        step();
        check("idle_spurious_rsp", 32'(rsp_data), 32'h15A5A);
        check("idle_spurious_busy", 32'(busy), 32'd0);

        // Fairness from reset, then wrap-around with req=1001.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        txn(4'b1111, 0, 18'h00011, lat);
        check("fair0_latency", 32'(lat), 32'd1);
        txn(4'b1111, 1, 18'h00022, lat);
        check("fair1_latency", 32'(lat), 32'd4);
        txn(4'b1111, 2, 18'h00033, lat);
        check("fair2_latency", 32'(lat), 32'd4);
        txn(4'b1111, 3, 18'h00044, lat);
        txn(4'b1001, 0, 18'h00055, lat);
        check("wrap_latency", 32'(lat), 32'd4);
        txn(4'b1001, 3, 18'h00066, lat);
        txn(4'b1001, 0, 18'h00077, lat);
        req = '0;
        repeat (3) step();
        check("after_wrap_idle", 32'(busy), 32'd0);

        // Spurious rx_valid during LAUNCH is ignored.
        req = 4'b0100;
        step();
        check("launch_tx", 32'(spi_tx_enable), 32'd1);
        check("launch_grant", 32'(grant_id), 32'd2);
        spi_rx_valid = 1'b1;
        spi_rx_data  = 18'h0AAAA;
        step();
        spi_rx_valid = 1'b0;
        check("launch_spurious_ack", 32'(ack), 32'd0);
        check("launch_spurious_rsp", 32'(rsp_data), 32'h00077);
        step();
        check("wait_hold_ack", 32'(ack), 32'd0);
        check("wait_hold_busy", 32'(busy), 32'd1);
        spi_rx_valid = 1'b1;
        spi_rx_data  = 18'h05555;
        step();
        spi_rx_valid = 1'b0;
        check("late_ack", 32'(ack), 32'b0100);
        check("late_rsp", 32'(rsp_data), 32'h05555);
        req = '0;
        repeat (3) step();

        // Reset during WAIT drops the transaction.
        req = 4'b0001;
        step();
        check("pre_reset_grant", 32'(spi_tx_enable), 32'd1);
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data_in", 32'(spi_data_in), 32'd0);
        check("midrst_mode", 32'(spi_mode), 32'd0);
        check("midrst_speed", 32'(spi_clock_speed), 32'd0);
        check("midrst_rsp", 32'(rsp_data), 32'd0);
        req = '0;
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_no_ack", 32'(ack), 32'd0);
        txn(4'b0010, 1, 18'h2BEEF, lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        req = '0;
        repeat (3) step();

`ifdef SPI_ARB_TIMEOUT_EN
        req = 4'b0100;
        step();
        check("tmo_launch", 32'(spi_tx_enable), 32'd1);
        check("tmo_grant", 32'(grant_id), 32'd2);
        early = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (ack != 4'b0000) early++;
        end
        check("tmo_no_early_ack", 32'(early), 32'd0);
        step();
        check("tmo_ack", 32'(ack), 32'b0100);
        check("tmo_flag", 32'(rsp_timeout), 32'd1);
        check("tmo_rsp_zero", 32'(rsp_data), 32'd0);
        req = '0;
        step();
        check("tmo_flag_clear", 32'(rsp_timeout), 32'd0);
        check("tmo_ack_clear", 32'(ack), 32'd0);
`else
        early = 0;
        req = 4'b0100;
        step();
        req = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ack != 4'b0000 || rsp_timeout != 1'b0) early++;
        end
        check("no_timeout_wait_forever", 32'(early), 32'd0);
        check("no_timeout_still_busy", 32'(busy), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and transaction sequencer sharing one `spi_full_duplex` master port among `NUM_REQ` requesters. It latches one requester's 18-bit word plus its SPI mode and clock speed, pulses the master's `tx_enable`, waits for `mrx_data_valid`, and returns the received word to the winner with a one-cycle ack. It sits between requester logic and the `tx_enable/data_in/spi_mode/clock_speed/master_out/mrx_data_valid` ports of `spi_full_duplex`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 18: SPI word width.
- `GAP_CYCLES`, 2: idle cycles between a response and the next arbitration, 1..15.
- `TIMEOUT_CYCLES`, 4096: WAIT watchdog limit, used only with `SPI_ARB_TIMEOUT_EN`.
- `sys_clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester level request; held until its ack.
- `req_data`  in  NUM_REQ*DATA_W  requester i's word at `[DATA_W*i +: DATA_W]`.
- `req_mode`  in  NUM_REQ*2  requester i's SPI mode at `[2*i +: 2]`.
- `req_speed`  in  NUM_REQ*2  requester i's clock speed at `[2*i +: 2]`.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_data`  out  DATA_W  received word; valid while `ack` is nonzero.
- `rsp_timeout`  out  1  high with `ack` when the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last winner.
- `spi_tx_enable`  out  1  one-cycle start pulse to the master `tx_enable`.
- `spi_data_in`  out  DATA_W  to master `data_in`.
- `spi_mode`  out  2  to master `spi_mode`.
- `spi_clock_speed`  out  2  to master `clock_speed`.
- `spi_rx_valid`  in  1  from master `mrx_data_valid`.
- `spi_rx_data`  in  DATA_W  from master `master_out`.

## Operation
- State machine: IDLE, LAUNCH, WAIT, RESP, GAP.
- IDLE, any `req` bit high:
  - Winner = first set bit searching from `last_grant+1` upward, with wrap-around modulo NUM_REQ.
  - Register the winner's data, mode and speed into `spi_data_in`, `spi_mode` and `spi_clock_speed`.
  - Update `grant_id`, then go to LAUNCH.
- LAUNCH: `spi_tx_enable`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On `spi_rx_valid`, capture `spi_rx_data` into `rsp_data` and go to RESP.
  - `spi_rx_valid` in any other state is ignored.
- RESP:
  - `ack[grant_id]`=1 for one cycle; `last_grant` ← `grant_id`.
  - Load the gap counter with GAP_CYCLES and go to GAP.
- GAP: count down; at 0, go to IDLE.
- The requester must drop `req` by the cycle after its ack, otherwise it is arbitrated again.
- If `req` is dropped mid-transaction, the transaction still completes and the ack is still pulsed.
- `spi_data_in`, `spi_mode` and `spi_clock_speed` stay stable from LAUNCH through the end of GAP, and hold their last value in IDLE.
- Changes to `req_*` inputs after the grant have no effect.
- All outputs are registered.

## Timing
- Reset values:
  - `ack`=0, `rsp_data`=0, `rsp_timeout`=0, `busy`=0, `grant_id`=0.
  - `spi_tx_enable`=0, `spi_data_in`=0, `spi_mode`=0, `spi_clock_speed`=0.
  - State = IDLE; `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- `req` high in IDLE at cycle t → `grant_id`/`spi_*` valid and `spi_tx_enable`=1 in cycle t+1.
- `spi_rx_valid` high at cycle w → `ack` and `rsp_data` in cycle w+1.
- After the ack cycle: GAP_CYCLES cycles in GAP, then IDLE.
- Earliest next `spi_tx_enable` = ack cycle + GAP_CYCLES + 2.
- `reset_n` low mid-transaction: immediate return to reset values; the in-flight transaction is dropped and no ack is issued.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - After TIMEOUT_CYCLES cycles without `spi_rx_valid`, go to RESP with `rsp_data`=0 and `rsp_timeout`=1.
  - `last_grant` still advances on a timeout.
- `SPI_ARB_TIMEOUT_EN` not defined:
  - The counter is not present.
  - WAIT waits indefinitely; `rsp_timeout` is tied to 0.

## Test plan
- Single request: `req`=4'b0001, data 18'h2A5A5, mode 2'b01, speed 2'b10 → `spi_tx_enable` pulses next cycle with those values; model returns 18'h15A5A → `ack`=4'b0001 and `rsp_data`=18'h15A5A one cycle after `spi_rx_valid`.
- Fairness: `req`=4'b1111 held, re-asserted after each ack → grant order 0,1,2,3,0; exactly one ack per transaction.
- Wrap-around: after a grant to 3, `req`=4'b1001 → grant 0, then grant 3 (if still requesting).
- Spurious `spi_rx_valid` during IDLE, LAUNCH or GAP → no ack, `rsp_data` unchanged.
- Reset mid-WAIT: assert `reset_n`=0 → all outputs 0 immediately; after release, `req`=4'b0010 → grant 1.
- With `SPI_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, model never responds → ack 17 cycles after LAUNCH with `rsp_timeout`=1 and `rsp_data`=0.
